// File: rtl/unary_op_pkg.sv
// Shared opcode encoding for the unary-op datapath.
package unary_op_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_LNOT = 3'd0,
    OP_BNOT = 3'd1,
    OP_RAND = 3'd2,
    OP_ROR  = 3'd3,
    OP_RXOR = 3'd4,
    OP_NEG  = 3'd5
  } op_e;

endpackage

// File: rtl/unary_alu.sv
// Combinational unary ALU: 1-bit results are zero-extended to WIDTH,
// opcodes 6 and 7 give a zero result with err set.
module unary_alu
  import unary_op_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y,
  output logic             err
);

  // opcode decode and evaluation
  always_comb begin
    y   = '0;
    err = 1'b0;
    case (op)
      OP_LNOT: y = {{(WIDTH-1){1'b0}}, ~|a};
      OP_BNOT: y = ~a;
      OP_RAND: y = {{(WIDTH-1){1'b0}}, &a};
      OP_ROR:  y = {{(WIDTH-1){1'b0}}, |a};
      OP_RXOR: y = {{(WIDTH-1){1'b0}}, ^a};
      OP_NEG:  y = -a;
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/unary_op_arbiter.sv
// Two-requester round-robin front end for the shared unary ALU, with a
// one-entry valid/ready result register and an accepted-op counter.
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_EMPTY | result register holds nothing, out_valid = 0
// ST_FULL  | result register holds a result, out_valid = 1
module unary_op_arbiter
  import unary_op_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OP_W-1:0]  req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OP_W-1:0]  req1_op,
  input  logic [WIDTH-1:0] req1_a,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_tag,
  output logic             out_err,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_e;

  state_e           r_state;
  state_e           w_state_nxt;
  logic             r_last_grant;
  logic [WIDTH-1:0] r_data;
  logic             r_tag;
  logic             r_err;
  logic [CNT_W-1:0] r_count;

  logic             w_can_accept;
  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_accept;
  logic [OP_W-1:0]  w_op;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_y;
  logic             w_err;

  // Under contention the requester that did not win last time gets the grant.
  assign w_can_accept = (r_state == ST_EMPTY) || out_ready;
  assign w_gnt0       = req0_valid && (!req1_valid || r_last_grant);
  assign w_gnt1       = req1_valid && (!req0_valid || !r_last_grant);
  assign w_accept     = (w_gnt0 || w_gnt1) && w_can_accept;

  assign req0_ready = w_gnt0 && w_can_accept;
  assign req1_ready = w_gnt1 && w_can_accept;

  assign w_op = w_gnt1 ? req1_op : req0_op;
  assign w_a  = w_gnt1 ? req1_a  : req0_a;

  unary_alu #(.WIDTH(WIDTH)) u_alu (
    .op  (w_op),
    .a   (w_a),
    .y   (w_y),
    .err (w_err)
  );

  // result register occupancy state
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_EMPTY;
    else     r_state <= w_state_nxt;
  end

  // occupancy next-state: a same-cycle consume plus accept stays FULL
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: if (w_accept)               w_state_nxt = ST_FULL;
      ST_FULL:  if (out_ready && !w_accept) w_state_nxt = ST_EMPTY;
      default:                              w_state_nxt = ST_EMPTY;
    endcase
  end

  // result payload, grant history and counter update only on acceptance
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data       <= '0;
      r_tag        <= 1'b0;
      r_err        <= 1'b0;
      r_count      <= '0;
      r_last_grant <= 1'b1;
    end else if (w_accept) begin
      r_data       <= w_y;
      r_tag        <= w_gnt1;
      r_err        <= w_err;
      r_count      <= r_count + CNT_W'(1);
      r_last_grant <= w_gnt1;
    end
  end

  assign out_valid = (r_state == ST_FULL);
  assign out_data  = r_data;
  assign out_tag   = r_tag;
  assign out_err   = r_err;
  assign op_count  = r_count;

endmodule
